// File: rtl/i2s_tx.sv
// I2S master transmitter: 16-bit stereo, 32 bclk slots per frame,
// standard one-bit-delayed MSB-first framing from a single clock.
module i2s_tx #(
    parameter int BCLK_DIV = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        frame_start,
    output logic        underrun,
    output logic        bclk,
    output logic        wclk,
    output logic        dout
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div;
    logic [4:0]    slot;
    logic [4:0]    slot_next;
    logic [31:0]   shifter;
    logic [15:0]   hold_left;
    logic [15:0]   hold_right;
    logic          div_end;
    logic          fall;
    logic          load;
    logic          take;

    assign div_end   = (div == DIV_LAST);
    assign fall      = div_end & bclk;
    assign slot_next = slot + 5'd1;
    assign load      = fall & (slot == 5'd31);
    assign take      = sample_valid & sample_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (div_end) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div  <= div + DW'(1);
        end
    end

    // Everything on the serial side moves only on bclk falling edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot    <= 5'd31;
            wclk    <= 1'b1;
            dout    <= 1'b0;
            shifter <= '0;
        end else if (fall) begin
            slot <= slot_next;
            wclk <= slot_next[4];
            dout <= shifter[31];
            if (load) begin
                shifter <= {hold_left, hold_right};
            end else begin
                shifter <= {shifter[30:0], 1'b0};
            end
        end
    end

    // A sample taken on the load clock lands in hold; the shifter already
    // took the old hold contents, so ready stays low for the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_left    <= '0;
            hold_right   <= '0;
            sample_ready <= 1'b1;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load & sample_ready;
            if (take) begin
                hold_left    <= left_in;
                hold_right   <= right_in;
                sample_ready <= 1'b0;
            end else if (load) begin
                sample_ready <= 1'b1;
            end
        end
    end

endmodule
